// File: rtl/alu_writeback_pkg.sv
// Shared definitions for the ez8 ALU writeback stage: width defaults,
// writeback state encoding and decode constants shared with the ALU.
package alu_writeback_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 8;
  localparam int unsigned ADDR_WIDTH_DEF = 8;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HOLD = 1'b1
  } wb_state_e;

  // Opcodes from the ALU decode whose effects surface here (retint, skip).
  localparam logic [7:0] OP_RET  = 8'h0E;
  localparam logic [7:0] OP_SKBC = 8'h70;

endpackage

// File: rtl/alu_writeback_if.sv
// ALU-to-writeback bus: instruction handshake, enables, register-file write
// port and the accumulator/flag forwarding path back to the ALU.
interface alu_writeback_if
  import alu_writeback_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF
);

  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] result;
  logic [ADDR_WIDTH-1:0] reg_addr;
  logic                  accum_write;
  logic                  reg_write;
  logic                  z_write;
  logic                  c_write;
  logic                  zout;
  logic                  cout;
  logic                  skip;
  logic                  retint;
  logic                  int_enter;

  logic                  rf_wr_en;
  logic [ADDR_WIDTH-1:0] rf_wr_addr;
  logic [DATA_WIDTH-1:0] rf_wr_data;
  logic                  rf_wr_ready;

  logic [DATA_WIDTH-1:0] accum;
  logic                  z_flag;
  logic                  c_flag;
  logic                  squash_next;
  logic                  retint_done;

  modport master (
    output in_valid, result, reg_addr, accum_write, reg_write, z_write,
           c_write, zout, cout, skip, retint, int_enter, rf_wr_ready,
    input  in_ready, rf_wr_en, rf_wr_addr, rf_wr_data, accum, z_flag,
           c_flag, squash_next, retint_done
  );

  modport slave (
    input  in_valid, result, reg_addr, accum_write, reg_write, z_write,
           c_write, zout, cout, skip, retint, int_enter, rf_wr_ready,
    output in_ready, rf_wr_en, rf_wr_addr, rf_wr_data, accum, z_flag,
           c_flag, squash_next, retint_done
  );

endinterface

// File: rtl/alu_writeback_wb_hold_buffer.sv
// One-entry register-file write buffer: captures a write the register file
// refused and presents it until the register file accepts it.
module wb_hold_buffer
  import alu_writeback_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_load,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_drain,
  output logic                  o_valid,
  output logic [ADDR_WIDTH-1:0] o_addr,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_ready
);

  logic                  r_valid;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
    end else if (i_load && !r_valid) begin
      r_valid <= 1'b1;
      r_addr  <= i_addr;
      r_data  <= i_data;
    end else if (r_valid && i_drain) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_addr  = r_addr;
  assign o_data  = r_data;
  assign o_ready = !r_valid;

endmodule

// File: rtl/alu_writeback.sv
// ez8 ALU writeback stage: commits accumulator/flags, squashes skipped
// instructions, keeps interrupt shadows and drives the register-file write.
module alu_writeback
  import alu_writeback_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input logic             clk,
  input logic             reset,
  alu_writeback_if.slave  bus
);

  wb_state_e             r_state;
  wb_state_e             w_state_next;

  logic [DATA_WIDTH-1:0] r_accum;
  logic                  r_z;
  logic                  r_c;
  logic [DATA_WIDTH-1:0] r_sh_accum;
  logic                  r_sh_z;
  logic                  r_sh_c;
  logic                  r_squash;
  logic                  r_retint_done;

  logic [DATA_WIDTH-1:0] w_accum_next;
  logic                  w_z_next;
  logic                  w_c_next;
  logic                  w_squash_next;

  logic                  w_in_ready;
  logic                  w_accept;
  logic                  w_commit;
  logic                  w_rf_issue;
  logic                  w_hold_load;
  logic                  w_hold_valid;
  logic                  w_hold_ready;
  logic [ADDR_WIDTH-1:0] w_hold_addr;
  logic [DATA_WIDTH-1:0] w_hold_data;

  logic                  w_rf_wr_en;
  logic [ADDR_WIDTH-1:0] w_rf_wr_addr;
  logic [DATA_WIDTH-1:0] w_rf_wr_data;

  assign w_accept    = bus.in_valid && w_in_ready;
  assign w_commit    = w_accept && !r_squash;
  assign w_rf_issue  = w_commit && bus.reg_write;
  assign w_hold_load = w_rf_issue && !bus.rf_wr_ready;

  wb_hold_buffer #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_hold (
    .clk     (clk),
    .reset   (reset),
    .i_load  (w_hold_load),
    .i_addr  (bus.reg_addr),
    .i_data  (bus.result),
    .i_drain (bus.rf_wr_ready),
    .o_valid (w_hold_valid),
    .o_addr  (w_hold_addr),
    .o_data  (w_hold_data),
    .o_ready (w_hold_ready)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_RUN;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_RUN:  if (w_hold_load)     w_state_next = ST_HOLD;
      ST_HOLD: if (bus.rf_wr_ready) w_state_next = ST_RUN;
    endcase
  end

  always_comb begin
    w_in_ready   = 1'b0;
    w_rf_wr_en   = 1'b0;
    w_rf_wr_addr = bus.reg_addr;
    w_rf_wr_data = bus.result;
    case (r_state)
      ST_RUN: begin
        w_in_ready = w_hold_ready;
        w_rf_wr_en = w_rf_issue;
      end
      ST_HOLD: begin
        w_rf_wr_en   = w_hold_valid;
        w_rf_wr_addr = w_hold_addr;
        w_rf_wr_data = w_hold_data;
      end
    endcase
  end

  // retint restores all three values and overrides the instruction's own writes.
  always_comb begin
    w_accum_next = r_accum;
    w_z_next     = r_z;
    w_c_next     = r_c;
    if (w_commit) begin
      if (bus.retint) begin
        w_accum_next = r_sh_accum;
        w_z_next     = r_sh_z;
        w_c_next     = r_sh_c;
      end else begin
        if (bus.accum_write) w_accum_next = bus.result;
        if (bus.z_write)     w_z_next     = bus.zout;
        if (bus.c_write)     w_c_next     = bus.cout;
      end
    end
  end

  always_comb begin
    w_squash_next = r_squash;
    if (bus.int_enter)  w_squash_next = 1'b0;
    else if (w_accept)  w_squash_next = w_commit && bus.skip;
  end

  // Shadows take post-commit values, so retint+int_enter leaves them unchanged.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_accum       <= '0;
      r_z           <= 1'b0;
      r_c           <= 1'b0;
      r_sh_accum    <= '0;
      r_sh_z        <= 1'b0;
      r_sh_c        <= 1'b0;
      r_squash      <= 1'b0;
      r_retint_done <= 1'b0;
    end else begin
      r_accum       <= w_accum_next;
      r_z           <= w_z_next;
      r_c           <= w_c_next;
      r_squash      <= w_squash_next;
      r_retint_done <= w_commit && bus.retint;
      if (bus.int_enter) begin
        r_sh_accum <= w_accum_next;
        r_sh_z     <= w_z_next;
        r_sh_c     <= w_c_next;
      end
    end
  end

  assign bus.in_ready    = w_in_ready;
  assign bus.rf_wr_en    = w_rf_wr_en;
  assign bus.rf_wr_addr  = w_rf_wr_addr;
  assign bus.rf_wr_data  = w_rf_wr_data;
  assign bus.accum       = r_accum;
  assign bus.z_flag      = r_z;
  assign bus.c_flag      = r_c;
  assign bus.squash_next = r_squash;
  assign bus.retint_done = r_retint_done;

endmodule

// File: tb/tb_alu_writeback.sv
// Directed self-checking bench for alu_writeback: inputs change and outputs
// are sampled on the falling clock edge, commits happen on the rising edge.
module tb_alu_writeback;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;

  alu_writeback_if #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) bus ();

  alu_writeback #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.in_valid    = 1'b0;
    bus.result      = '0;
    bus.reg_addr    = '0;
    bus.accum_write = 1'b0;
    bus.reg_write   = 1'b0;
    bus.z_write     = 1'b0;
    bus.c_write     = 1'b0;
    bus.zout        = 1'b0;
    bus.cout        = 1'b0;
    bus.skip        = 1'b0;
    bus.retint      = 1'b0;
    bus.int_enter   = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    idle();
    bus.rf_wr_ready = 1'b1;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk); #1;
    check("rst_accum", bus.accum, 8'h00);
    check("rst_z", bus.z_flag, 1'b0);
    check("rst_c", bus.c_flag, 1'b0);
    check("rst_squash", bus.squash_next, 1'b0);
    check("rst_rf_wr_en", bus.rf_wr_en, 1'b0);
    check("rst_retint_done", bus.retint_done, 1'b0);
    check("rst_in_ready", bus.in_ready, 1'b1);

    // Plain accumulator/Z commit, no register write
    bus.in_valid = 1'b1; bus.result = 8'h5A; bus.accum_write = 1'b1;
    bus.z_write = 1'b1; bus.zout = 1'b0;
    #1;
    check("t1_rf_wr_en", bus.rf_wr_en, 1'b0);
    check("t1_in_ready", bus.in_ready, 1'b1);
    @(negedge clk); idle(); #1;
    check("t1_accum", bus.accum, 8'h5A);
    check("t1_z", bus.z_flag, 1'b0);

    // Register write refused for 3 cycles, then accepted
    bus.in_valid = 1'b1; bus.reg_write = 1'b1; bus.reg_addr = 8'h12;
    bus.result = 8'h34; bus.rf_wr_ready = 1'b0;
    #1;
    check("t2_commit_en", bus.rf_wr_en, 1'b1);
    check("t2_commit_addr", bus.rf_wr_addr, 8'h12);
    check("t2_commit_data", bus.rf_wr_data, 8'h34);
    check("t2_commit_ready", bus.in_ready, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      idle(); bus.in_valid = 1'b1; bus.accum_write = 1'b1; bus.result = 8'h77;
      #1;
      check("t2_hold_ready", bus.in_ready, 1'b0);
      check("t2_hold_en", bus.rf_wr_en, 1'b1);
      check("t2_hold_addr", bus.rf_wr_addr, 8'h12);
      check("t2_hold_data", bus.rf_wr_data, 8'h34);
      check("t2_hold_accum", bus.accum, 8'h5A);
    end
    @(negedge clk); bus.rf_wr_ready = 1'b1; #1;
    check("t2_drain_en", bus.rf_wr_en, 1'b1);
    check("t2_drain_data", bus.rf_wr_data, 8'h34);
    check("t2_drain_ready", bus.in_ready, 1'b0);
    @(negedge clk); #1;
    check("t2_run_ready", bus.in_ready, 1'b1);
    check("t2_run_en", bus.rf_wr_en, 1'b0);
    @(negedge clk); idle(); #1;
    check("t2_stalled_instr", bus.accum, 8'h77);

    // Skip kills exactly the next instruction
    bus.in_valid = 1'b1; bus.skip = 1'b1;
    @(negedge clk); idle(); #1;
    check("t3_squash_set", bus.squash_next, 1'b1);
    bus.in_valid = 1'b1; bus.accum_write = 1'b1; bus.result = 8'hFF;
    @(negedge clk); idle(); #1;
    check("t3_killed_accum", bus.accum, 8'h77);
    check("t3_squash_clr", bus.squash_next, 1'b0);
    bus.in_valid = 1'b1; bus.accum_write = 1'b1; bus.result = 8'h01;
    @(negedge clk); idle(); #1;
    check("t3_third_accum", bus.accum, 8'h01);

    // Interrupt entry / return restores accum and flags
    bus.in_valid = 1'b1; bus.accum_write = 1'b1; bus.result = 8'hAA;
    bus.z_write = 1'b1; bus.zout = 1'b1; bus.c_write = 1'b1; bus.cout = 1'b1;
    @(negedge clk); idle(); #1;
    check("t4_accum_aa", bus.accum, 8'hAA);
    check("t4_z_set", bus.z_flag, 1'b1);
    check("t4_c_set", bus.c_flag, 1'b1);
    bus.int_enter = 1'b1;
    @(negedge clk); idle();
    bus.in_valid = 1'b1; bus.accum_write = 1'b1; bus.result = 8'h00;
    bus.c_write = 1'b1; bus.cout = 1'b0;
    @(negedge clk); idle(); #1;
    check("t4_isr_accum", bus.accum, 8'h00);
    check("t4_isr_c", bus.c_flag, 1'b0);
    check("t4_isr_z", bus.z_flag, 1'b1);
    check("t4_no_done_yet", bus.retint_done, 1'b0);
    bus.in_valid = 1'b1; bus.retint = 1'b1; bus.accum_write = 1'b1; bus.result = 8'h55;
    @(negedge clk); idle(); #1;
    check("t4_ret_accum", bus.accum, 8'hAA);
    check("t4_ret_z", bus.z_flag, 1'b1);
    check("t4_ret_c", bus.c_flag, 1'b1);
    check("t4_done_pulse", bus.retint_done, 1'b1);
    @(negedge clk); #1;
    check("t4_done_once", bus.retint_done, 1'b0);

    // int_enter with a same-edge commit captures post-commit value, clears skip
    bus.in_valid = 1'b1; bus.accum_write = 1'b1; bus.result = 8'h33;
    bus.skip = 1'b1; bus.int_enter = 1'b1;
    @(negedge clk); idle(); #1;
    check("t5_accum_33", bus.accum, 8'h33);
    check("t5_int_clr_squash", bus.squash_next, 1'b0);

    // retint together with int_enter: shadow keeps its old value
    bus.in_valid = 1'b1; bus.accum_write = 1'b1; bus.result = 8'h44;
    @(negedge clk); idle(); #1;
    check("t6_accum_44", bus.accum, 8'h44);
    bus.in_valid = 1'b1; bus.retint = 1'b1; bus.int_enter = 1'b1;
    @(negedge clk); idle(); #1;
    check("t6_restore_33", bus.accum, 8'h33);
    check("t6_done", bus.retint_done, 1'b1);
    bus.in_valid = 1'b1; bus.accum_write = 1'b1; bus.result = 8'h11;
    @(negedge clk); idle(); #1;
    check("t6_accum_11", bus.accum, 8'h11);
    bus.in_valid = 1'b1; bus.retint = 1'b1;
    @(negedge clk); idle(); #1;
    check("t6_shadow_kept", bus.accum, 8'h33);

    // Reset while a refused write is held discards it
    bus.in_valid = 1'b1; bus.reg_write = 1'b1; bus.reg_addr = 8'h56;
    bus.result = 8'h78; bus.rf_wr_ready = 1'b0;
    @(negedge clk); idle(); #1;
    check("t7_hold_en", bus.rf_wr_en, 1'b1);
    check("t7_hold_addr", bus.rf_wr_addr, 8'h56);
    check("t7_hold_ready", bus.in_ready, 1'b0);
    reset = 1'b1;
    @(negedge clk); reset = 1'b0; bus.rf_wr_ready = 1'b1; #1;
    check("t7_rst_en", bus.rf_wr_en, 1'b0);
    check("t7_rst_ready", bus.in_ready, 1'b1);
    check("t7_rst_accum", bus.accum, 8'h00);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      check("t7_never_issued", bus.rf_wr_en, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
